board_line_scanner: RTL and testbench
=====================================

BOARD_LINE_SCANNER -- requirements
Module: board_line_scanner

Interface
REQ-001 Parameter ROWS, default 20: number of playfield rows.
REQ-002 Parameter COLS, default 10: number of playfield columns.
REQ-003 Parameter AW, default 8: board RAM address width; ROWS*COLS SHALL be no greater than 2**AW.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  scan request; sampled only in IDLE.
REQ-007 rd_en  output  1  board RAM read enable.
REQ-008 rd_addr  output  AW  board RAM cell address, row*COLS+col, row 0 = top.
REQ-009 rd_data  input  3  cell colour code from board RAM; one-cycle synchronous read latency.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse marking scan complete.
REQ-012 full_rows  output  ROWS  bit r = row r completely occupied.
REQ-013 line_count  output  5  number of set bits in full_rows.
REQ-014 top_out  output  1  any occupied cell in row 0.

Function
REQ-015 The block SHALL decode each cell colour: 3'b000 = empty; any non-zero code (including 3'b111) = occupied.
REQ-016 FSM states SHALL be IDLE, SCAN, DRAIN and DONE; transitions: IDLE->SCAN on start; SCAN->DRAIN after address ROWS*COLS-1 is issued; DRAIN->DONE after one cycle; DONE->IDLE after one cycle.
REQ-017 start SHALL be ignored in SCAN, DRAIN and DONE.
REQ-018 Accepting start SHALL clear full_rows, line_count and top_out in the same edge that enters SCAN.
REQ-019 rd_en and rd_addr SHALL be registered; with start sampled at edge 0, rd_en SHALL be high in cycles 1..ROWS*COLS with rd_addr = cycle-1, and rd_addr SHALL increment by exactly 1 per SCAN cycle.
REQ-020 rd_data returned for address a SHALL be consumed in the cycle after a is presented (cycles 2..ROWS*COLS+1, the last of these in DRAIN).
REQ-021 A per-row AND accumulator SHALL reset to 1 at column 0 of each row; at column COLS-1 it SHALL write its final value into full_rows[row].
REQ-022 line_count SHALL increment when a row commits as full, saturating at 31.
REQ-023 top_out SHALL set on any occupied cell with row index 0.
REQ-024 done SHALL be high for exactly cycle ROWS*COLS+2 (cycle 202 at defaults).
REQ-025 Results SHALL be stable from done until the next accepted start.
REQ-026 start held continuously SHALL produce back-to-back scans, with the next scan accepted in the first IDLE cycle after DONE.
REQ-027 rd_en SHALL be low and rd_addr SHALL hold 0 outside SCAN.

Reset
REQ-028 While rst_n is low, the block SHALL be in IDLE with rd_en=0, rd_addr=0, busy=0, done=0, full_rows=0, line_count=0 and top_out=0.
REQ-029 Reset asserted mid-scan SHALL abort the scan immediately with the REQ-028 values, and no done pulse SHALL follow.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge that sees it high.

Verification
REQ-031 Empty board (all 3'b000), start pulse -> done in cycle 202, full_rows=0, line_count=0, top_out=0.
REQ-032 Rows 19 and 17 all 3'b101, rest empty -> full_rows=20'h A0000, line_count=2, top_out=0.
REQ-033 Row 5 full except col 9 empty; row 0 col 3 = 3'b111 -> full_rows=0, line_count=0, top_out=1.
REQ-034 start pulsed again in cycle 50 of a scan -> ignored; rd_addr sequence 0..199 unbroken; a single done pulse.
REQ-035 rst_n low in cycle 100 of a scan -> all outputs zero asynchronously; no done pulse; a fresh start gives correct results.
REQ-036 All rows full (mixed non-zero codes) -> full_rows=20'hFFFFF, line_count=20, top_out=1.

Source files
------------

// File: rtl/board_line_scanner.sv
// Scans the playfield RAM once per start request, reporting completely
// occupied rows, their count, and whether anything occupies the top row.
module board_line_scanner #(
  parameter int unsigned ROWS = 20,
  parameter int unsigned COLS = 10,
  parameter int unsigned AW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [2:0]      rd_data,
  output logic            busy,
  output logic            done,
  output logic [ROWS-1:0] full_rows,
  output logic [4:0]      line_count,
  output logic            top_out
);

  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            cvld_q, cvld_d;
  logic [RW-1:0]   crow_q, crow_d;
  logic [CW-1:0]   ccol_q, ccol_d;
  logic            acc_q, acc_d;
  logic [ROWS-1:0] full_rows_q, full_rows_d;
  logic [4:0]      line_count_q, line_count_d;
  logic            top_q, top_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            occupied;
  logic            acc_val;

  assign occupied = |rd_data;
  assign acc_val  = ((ccol_q == '0) ? 1'b1 : acc_q) & occupied;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cvld_q       <= 1'b0;
      crow_q       <= '0;
      ccol_q       <= '0;
      acc_q        <= 1'b0;
      full_rows_q  <= '0;
      line_count_q <= '0;
      top_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      row_q        <= row_d;
      col_q        <= col_d;
      cvld_q       <= cvld_d;
      crow_q       <= crow_d;
      ccol_q       <= ccol_d;
      acc_q        <= acc_d;
      full_rows_q  <= full_rows_d;
      line_count_q <= line_count_d;
      top_q        <= top_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = '0;
    row_d        = row_q;
    col_d        = col_q;
    // Issue position is delayed one cycle to line up with the RAM's read latency
    cvld_d       = rd_en_q;
    crow_d       = row_q;
    ccol_d       = col_q;
    acc_d        = acc_q;
    full_rows_d  = full_rows_q;
    line_count_d = line_count_q;
    top_d        = top_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          rd_en_d      = 1'b1;
          row_d        = '0;
          col_d        = '0;
          full_rows_d  = '0;
          line_count_d = '0;
          top_d        = 1'b0;
        end
      end
      SCAN: begin
        if (rd_addr_q == AW'(CELLS - 1)) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Consume returned cell: row AND accumulator, commit at last column
    if (cvld_q) begin
      acc_d = acc_val;
      if ((crow_q == '0) && occupied) begin
        top_d = 1'b1;
      end
      if (ccol_q == CW'(COLS - 1)) begin
        full_rows_d[crow_q] = acc_val;
        if (acc_val && (line_count_q != 5'd31)) begin
          line_count_d = line_count_q + 5'd1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign full_rows  = full_rows_q;
  assign line_count = line_count_q;
  assign top_out    = top_q;

endmodule

// File: tb/tb_board_line_scanner.sv
// Randomized scoreboard bench for board_line_scanner: a tracker predicts scan
// acceptance and results from the board contents, a monitor checks every cycle.
module tb_board_line_scanner;

  localparam int unsigned ROWS  = 20;
  localparam int unsigned COLS  = 10;
  localparam int unsigned AW    = 8;
  localparam int unsigned CELLS = ROWS * COLS;

  typedef struct {
    int              acc_edge;
    logic [ROWS-1:0] full;
    logic [4:0]      lines;
    logic            top;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [2:0]      rd_data = 3'd0;
  logic            busy;
  logic            done;
  logic [ROWS-1:0] full_rows;
  logic [4:0]      line_count;
  logic            top_out;

  logic [2:0] board [CELLS];
  exp_t       exp_q [$];
  exp_t       last_res;
  int         edge_idx  = 0;
  int         free_edge = 0;
  int         checks    = 0;
  int         errors    = 0;

  board_line_scanner #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .full_rows  (full_rows),
    .line_count (line_count),
    .top_out    (top_out)
  );

  always #5 clk = ~clk;

  // Board RAM with one-cycle synchronous read
  always @(posedge clk) begin
    if (rd_en && (rd_addr < AW'(CELLS))) rd_data <= board[rd_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int e);
    exp_t r;
    r.acc_edge = e;
    r.full     = '0;
    r.lines    = '0;
    r.top      = 1'b0;
    for (int row = 0; row < ROWS; row++) begin
      bit all_occ = 1'b1;
      for (int col = 0; col < COLS; col++) begin
        if (board[row*COLS+col] == 3'd0) all_occ = 1'b0;
        else if (row == 0) r.top = 1'b1;
      end
      if (all_occ) begin
        r.full[row] = 1'b1;
        if (r.lines != 5'd31) r.lines = r.lines + 5'd1;
      end
    end
    return r;
  endfunction

  // Tracker: a start seen at an edge while the block is free begins a scan
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && start && (edge_idx >= free_edge)) begin
        exp_q.push_back(model(edge_idx));
        free_edge = edge_idx + int'(CELLS) + 3;
      end
      edge_idx++;
    end
  end

  // Monitor: cycle-by-cycle comparison against the front expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_full_rows", 32'(full_rows), 0);
        check("rst_line_count", 32'(line_count), 0);
        check("rst_top_out", 32'(top_out), 0);
      end else if (exp_q.size() == 0) begin
        check("idle_rd_en", 32'(rd_en), 0);
        check("idle_rd_addr", 32'(rd_addr), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("hold_full_rows", 32'(full_rows), 32'(last_res.full));
        check("hold_line_count", 32'(line_count), 32'(last_res.lines));
        check("hold_top_out", 32'(top_out), 32'(last_res.top));
      end else begin
        exp_t f;
        int le, rel;
        logic e_rd;
        f   = exp_q[0];
        le  = edge_idx - 1;
        rel = le - f.acc_edge;
        e_rd = (rel >= 0) && (rel <= int'(CELLS) - 1);
        check("rd_en", 32'(rd_en), 32'(e_rd));
        check("rd_addr", 32'(rd_addr), e_rd ? 32'(rel) : 32'd0);
        check("busy", 32'(busy), 32'((rel >= 0) && (rel <= int'(CELLS) + 1)));
        check("done", 32'(done), 32'(rel == int'(CELLS) + 1));
        if (rel == 0) begin
          check("clr_full_rows", 32'(full_rows), 0);
          check("clr_line_count", 32'(line_count), 0);
          check("clr_top_out", 32'(top_out), 0);
        end
        if (rel >= int'(CELLS) + 1) begin
          check("res_full_rows", 32'(full_rows), 32'(f.full));
          check("res_line_count", 32'(line_count), 32'(f.lines));
          check("res_top_out", 32'(top_out), 32'(f.top));
          last_res = f;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic clear_board();
    for (int i = 0; i < int'(CELLS); i++) board[i] = 3'd0;
  endtask

  task automatic fill_row(input int r, input logic [2:0] code);
    for (int c = 0; c < int'(COLS); c++) board[r*COLS+c] = code;
  endtask

  task automatic random_board();
    for (int i = 0; i < int'(CELLS); i++) board[i] = 3'($urandom_range(0, 7));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3 * int'(CELLS) && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_timeout", 32'(exp_q.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    last_res.acc_edge = 0;
    last_res.full     = '0;
    last_res.lines    = '0;
    last_res.top      = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    clear_board();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Empty board
    pulse_start();
    wait_idle();

    // Rows 19 and 17 full
    clear_board();
    fill_row(19, 3'b101);
    fill_row(17, 3'b101);
    pulse_start();
    wait_idle();

    // Row 5 missing its last cell, one block in the top row
    clear_board();
    fill_row(5, 3'b011);
    board[5*COLS+9] = 3'd0;
    board[3] = 3'b111;
    pulse_start();
    wait_idle();

    // Second start mid-scan is ignored
    random_board();
    pulse_start();
    repeat (48) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in cycle 100 aborts the scan
    random_board();
    pulse_start();
    repeat (99) @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    free_edge = 0;
    last_res.full  = '0;
    last_res.lines = '0;
    last_res.top   = 1'b0;
    #1;
    check("async_rd_en", 32'(rd_en), 0);
    check("async_rd_addr", 32'(rd_addr), 0);
    check("async_busy", 32'(busy), 0);
    check("async_full_rows", 32'(full_rows), 0);
    check("async_line_count", 32'(line_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    random_board();
    pulse_start();
    wait_idle();

    // Every row full with mixed codes
    for (int i = 0; i < int'(CELLS); i++) board[i] = 3'($urandom_range(1, 7));
    pulse_start();
    wait_idle();

    // Held start gives back-to-back scans
    random_board();
    @(negedge clk);
    start = 1'b1;
    repeat (int'(CELLS) + 5) @(negedge clk);
    start = 1'b0;
    wait_idle();
    wait_idle();

    // Random boards
    for (int k = 0; k < 6; k++) begin
      random_board();
      if (k == 2) clear_board();
      pulse_start();
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
